result_drain: RTL and testbench

//  Reader for the result (W) memory that the Controller writes during a run.

---
 rtl/result_drain.sv | 187 ++++++++++++++++++
 tb/tb_result_drain.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/result_drain.sv
// result_drain: reads a block of result words from the W SRAM once the
// Controller is idle and streams them to the host over valid/ready.
//
// Ports:
//   clk        system clock, rising edge
//   reset      asynchronous active-low reset
//   start      one-cycle drain request, accepted only when idle
//   base_addr  first W address, sampled on start acceptance
//   count      number of words (0..2^ADDR_W), sampled on start acceptance
//   busy       Controller busy; no read is issued while high
//   mem_addr   W SRAM read address
//   mem_re     W SRAM read enable, data returns on mem_rdata next cycle
//   mem_rdata  W SRAM read data
//   out_data   streamed word (FIFO head)
//   out_valid  out_data valid
//   out_ready  host accepts word on out_valid && out_ready
//   out_last   marks the final word of the block
//   active     high from start acceptance until done
//   done       one-cycle pulse after the last word is accepted
module result_drain #(
    parameter int unsigned ADDR_W     = 12,
    parameter int unsigned DATA_W     = 16,
    parameter int unsigned FIFO_DEPTH = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [ADDR_W:0]   count,
    input  logic              busy,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_re,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic [DATA_W-1:0] out_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              out_last,
    output logic              active,
    output logic              done
);

    localparam int unsigned PTR_W = (FIFO_DEPTH > 2) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned OCC_W = PTR_W + 1;

    typedef enum logic [2:0] {StIdle, StWait, StRead, StFlush, StDone} state_e;

    state_e state_q, state_d;

    logic [ADDR_W-1:0] addr_q;
    logic [ADDR_W:0]   issue_left_q;
    logic [ADDR_W:0]   out_left_q;
    logic              inflight_q;

    logic [DATA_W-1:0] fifo_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q, rd_ptr_q;
    logic [OCC_W-1:0]  occ_q;

    logic             start_ok;
    logic             push, pop;
    logic             can_issue;
    logic [OCC_W:0]   credit;

    assign start_ok = (state_q == StIdle) && start;
    assign push     = inflight_q;
    assign pop      = out_valid && out_ready;

    // Slots committed after this cycle's pop; counting the pop lets a full
    // FIFO accept a new read in the same cycle it drains, for full throughput.
    assign credit = (OCC_W+1)'(occ_q) + (OCC_W+1)'(inflight_q) - (OCC_W+1)'(pop);

    assign can_issue = !busy && (issue_left_q != '0) &&
                       (credit < (OCC_W+1)'(FIFO_DEPTH));

    // State register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: begin
                if (start) begin
                    state_d = (count == '0) ? StDone : StWait;
                end
            end
            StWait: begin
                if (!busy) begin
                    state_d = StRead;
                end
            end
            StRead: begin
                if (can_issue && (issue_left_q == (ADDR_W+1)'(1))) begin
                    state_d = StFlush;
                end
            end
            StFlush: begin
                if (pop && out_last) begin
                    state_d = StDone;
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    // FSM outputs
    always_comb begin
        mem_re = 1'b0;
        active = 1'b0;
        done   = 1'b0;
        unique case (state_q)
            StIdle:  ;
            StWait:  active = 1'b1;
            StRead: begin
                active = 1'b1;
                mem_re = can_issue;
            end
            StFlush: active = 1'b1;
            StDone:  done = 1'b1;
            default: ;
        endcase
    end

    // Address and word counters
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            addr_q       <= '0;
            issue_left_q <= '0;
            out_left_q   <= '0;
            inflight_q   <= 1'b0;
        end else begin
            inflight_q <= mem_re;
            if (start_ok) begin
                addr_q       <= base_addr;
                issue_left_q <= count;
                out_left_q   <= count;
            end else begin
                if (mem_re) begin
                    addr_q       <= addr_q + ADDR_W'(1);
                    issue_left_q <= issue_left_q - (ADDR_W+1)'(1);
                end
                if (pop) begin
                    out_left_q <= out_left_q - (ADDR_W+1)'(1);
                end
            end
        end
    end

    // Output FIFO; storage is cleared so out_data reads 0 out of reset
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < int'(FIFO_DEPTH); i++) begin
                fifo_mem[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            occ_q    <= '0;
        end else begin
            if (push) begin
                fifo_mem[wr_ptr_q] <= mem_rdata;
                wr_ptr_q           <= wr_ptr_q + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   occ_q <= occ_q + OCC_W'(1);
                2'b01:   occ_q <= occ_q - OCC_W'(1);
                default: occ_q <= occ_q;
            endcase
        end
    end

    assign mem_addr  = addr_q;
    assign out_valid = (occ_q != '0);
    assign out_data  = fifo_mem[rd_ptr_q];
    assign out_last  = out_valid && (out_left_q == (ADDR_W+1)'(1));

endmodule

// File: tb/tb_result_drain.sv
module tb_result_drain;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [11:0] base_addr;
    logic [12:0] count;
    logic        busy;
    logic [11:0] mem_addr;
    logic        mem_re;
    logic [15:0] mem_rdata;
    logic [15:0] out_data;
    logic        out_valid;
    logic        out_ready;
    logic        out_last;
    logic        active;
    logic        done;

    result_drain #(
        .ADDR_W    (12),
        .DATA_W    (16),
        .FIFO_DEPTH(2)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .base_addr(base_addr),
        .count    (count),
        .busy     (busy),
        .mem_addr (mem_addr),
        .mem_re   (mem_re),
        .mem_rdata(mem_rdata),
        .out_data (out_data),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_last (out_last),
        .active   (active),
        .done     (done)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;
    int cyc   = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // SRAM model: word at address A is {4'hC, A}, one cycle read latency
    always @(posedge clk) begin
        if (mem_re) mem_rdata <= {4'hC, mem_addr};
    end

    // Log of reads, handshakes and done pulses, sampled mid-cycle
    logic [11:0] addr_log [$];
    logic [15:0] data_log [$];
    logic        last_log [$];
    int          hs_cyc   [$];
    int          re_cyc   [$];
    int          re_tot, hs_tot, done_cnt, done_cyc, valid_cnt, stab_err, max_out;
    logic        prev_stall;
    logic [15:0] prev_data;
    logic        prev_last;

    always @(negedge clk) begin
        if (re_tot - hs_tot > max_out) max_out <= re_tot - hs_tot;
        if (mem_re) begin
            addr_log.push_back(mem_addr);
            re_cyc.push_back(cyc);
            re_tot <= re_tot + 1;
        end
        if (out_valid) valid_cnt <= valid_cnt + 1;
        if (out_valid && out_ready) begin
            data_log.push_back(out_data);
            last_log.push_back(out_last);
            hs_cyc.push_back(cyc);
            hs_tot <= hs_tot + 1;
        end
        if (done) begin
            done_cnt <= done_cnt + 1;
            done_cyc <= cyc;
        end
        if (prev_stall && !(out_valid && out_data == prev_data && out_last == prev_last))
            stab_err <= stab_err + 1;
        prev_stall <= out_valid && !out_ready;
        prev_data  <= out_data;
        prev_last  <= out_last;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_log();
        addr_log.delete();
        data_log.delete();
        last_log.delete();
        hs_cyc.delete();
        re_cyc.delete();
        re_tot = 0; hs_tot = 0; done_cnt = 0; done_cyc = 0;
        valid_cnt = 0; stab_err = 0; max_out = 0;
        prev_stall = 1'b0;
    endtask

    task automatic kick(input logic [11:0] base, input logic [12:0] n);
        start     = 1'b1;
        base_addr = base;
        count     = n;
        step();
        start = 1'b0;
    endtask

    task automatic run_until_done(input string tag, input int limit, input bit toggle);
        for (int i = 0; i < limit && done_cnt == 0; i++) begin
            if (toggle) out_ready = ~out_ready;
            step();
        end
        check({tag, "_done_seen"}, 32'(done_cnt != 0), 32'd1);
        step();
        out_ready = 1'b1;
    endtask

    // Compares logged addresses, words and last flags against base..base+n-1
    task automatic check_block(input string tag, input logic [11:0] base, input int n);
        logic [11:0] a;
        check({tag, "_nreads"}, 32'(addr_log.size()), 32'(n));
        check({tag, "_nwords"}, 32'(data_log.size()), 32'(n));
        for (int i = 0; i < n; i++) begin
            a = base + 12'(i);
            check({tag, "_addr"}, 32'(addr_log[i]), 32'(a));
            check({tag, "_data"}, 32'(data_log[i]), 32'({4'hC, a}));
            check({tag, "_last"}, 32'(last_log[i]), 32'(i == n - 1));
        end
        check({tag, "_done_once"}, 32'(done_cnt), 32'd1);
        check({tag, "_done_after_last"}, 32'(done_cyc), 32'(hs_cyc[n-1] + 1));
    endtask

    initial begin
        reset     = 1'b0;
        start     = 1'b0;
        base_addr = '0;
        count     = '0;
        busy      = 1'b0;
        out_ready = 1'b1;
        mem_rdata = '0;
        clear_log();
        step();
        check("rst_mem_addr", 32'(mem_addr), 32'h0);
        check("rst_mem_re", 32'(mem_re), 32'h0);
        check("rst_out_valid", 32'(out_valid), 32'h0);
        check("rst_out_data", 32'(out_data), 32'h0);
        check("rst_active", 32'(active), 32'h0);
        check("rst_done", 32'(done), 32'h0);
        reset = 1'b1;
        step();

        // Basic block at full throughput
        clear_log();
        kick(12'h010, 13'd4);
        check("basic_active", 32'(active), 32'h1);
        run_until_done("basic", 50, 1'b0);
        check_block("basic", 12'h010, 4);
        check("basic_latency", 32'(hs_cyc[0] - re_cyc[0]), 32'd2);
        check("basic_throughput", 32'(hs_cyc[3] - hs_cyc[0]), 32'd3);
        check("basic_idle_after", 32'(active), 32'h0);

        // Address wrap
        clear_log();
        kick(12'hFFE, 13'd4);
        run_until_done("wrap", 50, 1'b0);
        check_block("wrap", 12'hFFE, 4);

        // Held off by busy for 20 cycles
        clear_log();
        busy = 1'b1;
        kick(12'h080, 13'd2);
        for (int i = 0; i < 20; i++) step();
        check("busy_no_read", 32'(re_tot), 32'd0);
        check("busy_active", 32'(active), 32'h1);
        busy = 1'b0;
        begin
            int c0;
            c0 = cyc;
            run_until_done("busy", 50, 1'b0);
            check("busy_first_read", 32'(re_cyc[0]), 32'(c0 + 1));
        end
        check_block("busy", 12'h080, 2);

        // Back-pressure with out_ready toggling every cycle
        clear_log();
        out_ready = 1'b0;
        kick(12'h100, 13'd8);
        run_until_done("bp", 100, 1'b1);
        check_block("bp", 12'h100, 8);
        check("bp_stable", 32'(stab_err), 32'd0);
        check("bp_max_outstanding_le2", 32'(max_out <= 2), 32'd1);

        // Zero-length block
        clear_log();
        kick(12'h123, 13'd0);
        check("zero_done", 32'(done), 32'h1);
        check("zero_active", 32'(active), 32'h0);
        step();
        check("zero_done_pulse", 32'(done), 32'h0);
        check("zero_no_read", 32'(re_tot), 32'd0);
        check("zero_no_valid", 32'(valid_cnt), 32'd0);

        // Second start while active is ignored
        clear_log();
        busy = 1'b1;
        kick(12'h200, 13'd4);
        step();
        kick(12'h300, 13'd2);
        step();
        busy = 1'b0;
        run_until_done("restart", 50, 1'b0);
        check_block("restart", 12'h200, 4);

        // Reset mid-block, then a fresh block
        clear_log();
        kick(12'h400, 13'd8);
        for (int i = 0; i < 50 && hs_tot < 3; i++) step();
        check("abort_progress", 32'(hs_tot), 32'd3);
        reset = 1'b0;
        #1;
        check("abort_mem_addr", 32'(mem_addr), 32'h0);
        check("abort_mem_re", 32'(mem_re), 32'h0);
        check("abort_out_valid", 32'(out_valid), 32'h0);
        check("abort_out_data", 32'(out_data), 32'h0);
        check("abort_out_last", 32'(out_last), 32'h0);
        check("abort_active", 32'(active), 32'h0);
        step();
        step();
        check("abort_no_done", 32'(done_cnt), 32'd0);
        reset = 1'b1;
        step();
        clear_log();
        kick(12'h500, 13'd2);
        run_until_done("fresh", 50, 1'b0);
        check_block("fresh", 12'h500, 2);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
